// File: rtl/btb_branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters for the IF/EX stages.
// Latency: lookup and mispredict/redirect are combinational (0 cycles); training lands at the next edge.
// Backpressure: none; one lookup and one update are accepted every cycle.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   if_pc                 fetch PC to look up
//   pred_taken/target     fetch prediction (target = if_pc+4 when not predicted taken)
//   ex_*                  resolved branch/jump from EX, with the prediction carried down the pipe
//   clear_all             invalidate every entry
//   mispredict/redirect   flush request and correct next PC
//   stat_updates/mispred  saturating statistics
module btb_branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              ex_upd_valid,
  input  logic              ex_is_cond,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  input  logic              clear_all,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  // Weakly-taken starting point for a freshly allocated conditional branch.
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

  // Entry storage
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];

  logic [STAT_W-1:0] stat_upd_q, stat_upd_d;
  logic [STAT_W-1:0] stat_mis_q, stat_mis_d;

  // ---------------------------------------------------------------- lookup
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic             if_taken;

  assign if_idx   = if_pc[IDX_W+1:2];
  assign if_tag   = if_pc[ADDR_W-1:IDX_W+2];
  assign if_hit   = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_taken = if_hit && ctr_q[if_idx][CTR_W-1];

  // Outputs are held at zero while reset is asserted so the PC mux sees a quiet BTB.
  assign pred_taken  = reset && if_taken;
  assign pred_target = !reset   ? '0 :
                       if_taken ? tgt_q[if_idx] :
                                  if_pc + ADDR_W'(4);

  // ---------------------------------------------------------- resolution
  logic eff_taken;
  logic mis_raw;

  // Jumps are always taken regardless of ex_taken.
  assign eff_taken = ex_is_cond ? ex_taken : 1'b1;
  assign mis_raw   = ex_upd_valid &&
                     ((ex_pred_taken != eff_taken) ||
                      (eff_taken && (ex_pred_target != ex_target)));

  assign mispredict  = reset && mis_raw;
  assign redirect_pc = !reset    ? '0 :
                       eff_taken ? ex_target :
                                   ex_pc + ADDR_W'(4);

  // -------------------------------------------------------------- training
  logic [IDX_W-1:0]  ex_idx;
  logic [TAG_W-1:0]  ex_tag;
  logic              ex_hit;
  logic              ent_wr;
  logic [CTR_W-1:0]  ent_ctr_d;
  logic [ADDR_W-1:0] ent_tgt_d;

  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[ADDR_W-1:IDX_W+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // A not-taken miss leaves the table alone; anything else writes the indexed entry
  // (on a miss this evicts whatever alias lived there).
  assign ent_wr = ex_upd_valid && (ex_hit || eff_taken);

  always_comb begin
    ent_ctr_d = ctr_q[ex_idx];
    ent_tgt_d = tgt_q[ex_idx];
    if (eff_taken) begin
      ent_tgt_d = ex_target;
    end
    if (!ex_hit) begin
      ent_ctr_d = ex_is_cond ? CTR_INIT : CTR_MAX;
    end else if (!ex_is_cond) begin
      ent_ctr_d = CTR_MAX;
    end else if (ex_taken) begin
      if (ctr_q[ex_idx] != CTR_MAX) begin
        ent_ctr_d = ctr_q[ex_idx] + CTR_W'(1);
      end
    end else begin
      if (ctr_q[ex_idx] != '0) begin
        ent_ctr_d = ctr_q[ex_idx] - CTR_W'(1);
      end
    end
  end

  // Statistics saturate at all-ones instead of wrapping.
  always_comb begin
    stat_upd_d = stat_upd_q;
    stat_mis_d = stat_mis_q;
    if (ex_upd_valid && (stat_upd_q != {STAT_W{1'b1}})) begin
      stat_upd_d = stat_upd_q + STAT_W'(1);
    end
    if (mis_raw && (stat_mis_q != {STAT_W{1'b1}})) begin
      stat_mis_d = stat_mis_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q    <= '0;
      stat_upd_q <= '0;
      stat_mis_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else begin
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
      // clear_all wins over a concurrent update; the update is dropped but still counted.
      if (clear_all) begin
        valid_q <= '0;
      end else if (ent_wr) begin
        valid_q[ex_idx] <= 1'b1;
        tag_q[ex_idx]   <= ex_tag;
        tgt_q[ex_idx]   <= ent_tgt_d;
        ctr_q[ex_idx]   <= ent_ctr_d;
      end
    end
  end

  assign stat_updates     = stat_upd_q;
  assign stat_mispredicts = stat_mis_q;

endmodule
